capture_arbiter: RTL

Round-robin arbiter that shares one capture register between `N_REQ` requesters. A requester raises its request with a data word. The arbiter grants one requester, latches its word into the shared register, and holds it valid until a downstream consumer acknowledges it or a timeout expires. It sits between the stimulus-side sources and the single sampling flop bank. It is the sequencing/sharing controller for that register.

---
 rtl/capture_arbiter_pkg.sv | 23 ++
 rtl/capture_arbiter_rr_pick.sv | 37 +++
 rtl/capture_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/capture_arbiter_pkg.sv
// Shared definitions for the capture arbiter: state encoding, index-width
// helper and the DIN slice-offset helper.
package capture_arbiter_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    typedef enum logic {
        IDLE = ST_IDLE,
        HOLD = ST_HOLD
    } state_e;

    // Index width for a count of n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Low bit of requester idx's word in the flattened DIN bus.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/capture_arbiter_rr_pick.sv
// rr_pick: rotating-priority picker. Returns the first set request at or
// after ptr (wrapping) and whether any request is set.
module capture_arbiter_rr_pick
    import capture_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    sel,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic [IW-1:0]    off;
    int               sum;

    always_comb begin
        rot = '0;
        off = '0;
        sum = 0;
        // Rotate so bit 0 is the highest-priority requester.
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req[(i + int'(ptr)) % N_REQ];
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IW'(i);
        end
        // Undo the rotation; N_REQ need not be a power of two.
        sum = int'(off) + int'(ptr);
        if (sum >= N_REQ) sum = sum - N_REQ;
        sel = IW'(sum);
        any = |req;
    end

endmodule

// File: rtl/capture_arbiter.sv
// Round-robin arbiter sharing one capture register between N_REQ requesters;
// a latched sample is held until ACK or until TIMEOUT cycles elapse.
module capture_arbiter
    import capture_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [N_REQ-1:0]          REQ,
    input  logic [N_REQ*W-1:0]        DIN,
    input  logic                      ACK,
    output logic [N_REQ-1:0]          GNT,
    output logic [W-1:0]              Q,
    output logic [idx_w(N_REQ)-1:0]   Q_SRC,
    output logic                      Q_VALID,
    output logic                      TIMEOUT_ERR
);

    localparam int IW = idx_w(N_REQ);
    localparam int CW = idx_w(TIMEOUT);

    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    wcnt_q, wcnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [W-1:0]     q_q, q_d;
    logic [IW-1:0]    q_src_q, q_src_d;
    logic             q_valid_q, q_valid_d;
    logic             terr_q, terr_d;

    logic [IW-1:0]    sel;
    logic             any;
    logic [IW-1:0]    nxt_ptr;

    capture_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req (REQ),
        .ptr (ptr_q),
        .sel (sel),
        .any (any)
    );

    // Priority moves to the requester just after the one being released.
    always_comb begin
        nxt_ptr = (q_src_q == IW'(N_REQ - 1)) ? '0 : q_src_q + IW'(1);
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wcnt_d    = wcnt_q;
        gnt_d     = '0;
        q_d       = q_q;
        q_src_d   = q_src_q;
        q_valid_d = q_valid_q;
        terr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    gnt_d     = N_REQ'(1) << sel;
                    q_d       = DIN[slice_lo(int'(sel), W) +: W];
                    q_src_d   = sel;
                    q_valid_d = 1'b1;
                    wcnt_d    = '0;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                // ACK takes precedence over an expiring timeout.
                if (ACK) begin
                    q_valid_d = 1'b0;
                    ptr_d     = nxt_ptr;
                    state_d   = IDLE;
                end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
                    q_valid_d = 1'b0;
                    terr_d    = 1'b1;
                    ptr_d     = nxt_ptr;
                    state_d   = IDLE;
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            wcnt_q    <= '0;
            gnt_q     <= '0;
            q_q       <= '0;
            q_src_q   <= '0;
            q_valid_q <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wcnt_q    <= wcnt_d;
            gnt_q     <= gnt_d;
            q_q       <= q_d;
            q_src_q   <= q_src_d;
            q_valid_q <= q_valid_d;
            terr_q    <= terr_d;
        end
    end

    assign GNT         = gnt_q;
    assign Q           = q_q;
    assign Q_SRC       = q_src_q;
    assign Q_VALID     = q_valid_q;
    assign TIMEOUT_ERR = terr_q;

endmodule
